// File: rtl/fifo_sync_param_if.sv
// fifo_sync_param_if: write/read handshake and status bundle for fifo_sync_param.
// Latency: none; wires only.
// Backpressure: master watches o_full/o_empty; the FIFO drops writes when full and reads when empty.
interface fifo_sync_param_if #(
   parameter int bw    = 4,
   parameter int simd  = 1,
   parameter int depth = 64
);
   localparam int W  = simd * bw;
   localparam int CW = $clog2(depth) + 1;

   logic [W-1:0]  in;
   logic          wr;
   logic          rd;
   logic [W-1:0]  out;
   logic          o_full;
   logic          o_empty;
   logic          o_almost_full;
   logic          o_almost_empty;
   logic [CW-1:0] o_count;
   logic          o_overflow;
   logic          o_underflow;

   modport master (
      output in, wr, rd,
      input  out, o_full, o_empty, o_almost_full, o_almost_empty,
             o_count, o_overflow, o_underflow
   );

   modport slave (
      input  in, wr, rd,
      output out, o_full, o_empty, o_almost_full, o_almost_empty,
             o_count, o_overflow, o_underflow
   );
endinterface

// File: rtl/fifo_sync_param.sv
// fifo_sync_param: show-ahead synchronous FIFO with occupancy count and threshold flags.
// Latency: a write reaches out the cycle after it lands at the head; out = mem[rd_ptr] with zero read latency.
// Backpressure: writes dropped when full unless a read is accepted the same cycle; reads dropped when empty.
// Optional macro FIFO_ERR_STICKY_EN adds sticky overflow/underflow flags (otherwise both tie to 0).
module fifo_sync_param #(
   parameter int bw       = 4,
   parameter int simd     = 1,
   parameter int depth    = 64,
   parameter int af_level = 60,
   parameter int ae_level = 4
) (
   input logic             clk,
   input logic             reset,
   fifo_sync_param_if.slave bus
);
   localparam int W  = simd * bw;
   localparam int AW = $clog2(depth);
   localparam int CW = AW + 1;
   localparam logic [CW-1:0] DEPTH_C = CW'(depth);
   localparam logic [CW-1:0] AF_C    = CW'(af_level);
   localparam logic [CW-1:0] AE_C    = CW'(ae_level);

   // Storage is deliberately left unreset; out is undefined until the head has been written.
   logic [W-1:0]  mem [depth];

   // Pointers carry one extra wrap bit so full and empty stay distinguishable.
   logic [CW-1:0] wr_ptr_q, wr_ptr_d;
   logic [CW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count;
   logic          full;
   logic          empty;
   logic          rd_acc;
   logic          wr_acc;

   // Status comes only from registered pointers, never from this cycle's rd/wr.
   assign count = wr_ptr_q - rd_ptr_q;
   assign full  = (count == DEPTH_C);
   assign empty = (count == '0);

   assign bus.o_count        = count;
   assign bus.o_full         = full;
   assign bus.o_empty        = empty;
   assign bus.o_almost_full  = (count >= AF_C);
   assign bus.o_almost_empty = (count <= AE_C);
   assign bus.out            = mem[rd_ptr_q[AW-1:0]];

   // Accept decisions and next pointers; a read while full frees the slot a same-cycle write needs.
   always_comb begin
      rd_acc   = bus.rd && !empty;
      wr_acc   = bus.wr && (!full || rd_acc);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (wr_acc) begin
         wr_ptr_d = wr_ptr_q + CW'(1);
      end
      if (rd_acc) begin
         rd_ptr_d = rd_ptr_q + CW'(1);
      end
   end

   // Pointer registers; reset wins over any concurrent rd/wr.
   always_ff @(posedge clk) begin
      if (reset) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
      end
   end

   // Storage write at the tail for each accepted write.
   always_ff @(posedge clk) begin
      if (!reset && wr_acc) begin
         mem[wr_ptr_q[AW-1:0]] <= bus.in;
      end
   end

`ifdef FIFO_ERR_STICKY_EN
   logic ovf_q, ovf_d;
   logic unf_q, unf_d;

   // Error flags latch on any dropped request and hold until reset.
   always_comb begin
      ovf_d = ovf_q | (bus.wr && !wr_acc);
      unf_d = unf_q | (bus.rd && empty);
   end

   // Sticky error registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_d;
         unf_q <= unf_d;
      end
   end

   assign bus.o_overflow  = ovf_q;
   assign bus.o_underflow = unf_q;
`else
   assign bus.o_overflow  = 1'b0;
   assign bus.o_underflow = 1'b0;
`endif
endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: directed checks of fifo_sync_param at depth 8, af_level 6, ae_level 1.
// Latency: outputs sampled 1 time unit after each rising edge.
// Backpressure: exercises full/empty rejection, simultaneous rd/wr and reset priority.
module tb_fifo_sync_param;
   logic clk = 1'b0;
   logic reset;

   always #5 clk = ~clk;

   fifo_sync_param_if #(.bw(4), .simd(1), .depth(8)) bus ();

   fifo_sync_param #(
      .bw(4), .simd(1), .depth(8), .af_level(6), .ae_level(1)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus)
   );

`ifdef FIFO_ERR_STICKY_EN
   localparam logic STICKY = 1'b1;
`else
   localparam logic STICKY = 1'b0;
`endif

   int checks   = 0;
   int failures = 0;
   logic [3:0] q[$];

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_status(input string tag, input int n);
      check({tag, ".count"}, 32'(bus.o_count), 32'(n));
      check({tag, ".empty"}, 32'(bus.o_empty), 32'(n == 0));
      check({tag, ".full"},  32'(bus.o_full),  32'(n == 8));
      check({tag, ".af"},    32'(bus.o_almost_full),  32'(n >= 6));
      check({tag, ".ae"},    32'(bus.o_almost_empty), 32'(n <= 1));
   endtask

   task automatic step(input logic w, input logic r, input logic [3:0] d);
      bus.wr = w;
      bus.rd = r;
      bus.in = d;
      @(posedge clk);
      #1;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
   endtask

   // One cycle with a queue model deciding acceptance from its own occupancy.
   task automatic mstep(input logic w, input logic r, input logic [3:0] d);
      logic r_acc, w_acc;
      r_acc = r && (q.size() > 0);
      w_acc = w && ((q.size() < 8) || r_acc);
      step(w, r, d);
      if (r_acc) void'(q.pop_front());
      if (w_acc) q.push_back(d);
      check("burst.count", 32'(bus.o_count), 32'(q.size()));
      if (q.size() > 0) check("burst.out", 32'(bus.out), 32'(q[0]));
   endtask

   initial begin
      int written;
      // Reset held with rd/wr active.
      reset  = 1'b1;
      bus.wr = 1'b1;
      bus.rd = 1'b1;
      bus.in = 4'h5;
      repeat (2) @(posedge clk);
      #1;
      reset  = 1'b0;
      bus.wr = 1'b0;
      bus.rd = 1'b0;
      chk_status("reset", 0);
      check("reset.ovf", 32'(bus.o_overflow), 32'(0));
      check("reset.unf", 32'(bus.o_underflow), 32'(0));

      // Fill 1..8.
      for (int i = 1; i <= 8; i++) begin
         step(1'b1, 1'b0, 4'(i));
         chk_status("fill", i);
         check("fill.out", 32'(bus.out), 32'(1));
      end

      // Write while full is dropped.
      step(1'b1, 1'b0, 4'hF);
      chk_status("ovf", 8);
      check("ovf.out", 32'(bus.out), 32'(1));
      check("ovf.flag", 32'(bus.o_overflow), 32'(STICKY));

      // Drain in order 1..8.
      for (int i = 1; i <= 8; i++) begin
         check("drain.out", 32'(bus.out), 32'(i));
         step(1'b0, 1'b1, 4'h0);
         chk_status("drain", 8 - i);
      end

      // rd+wr while empty: write only, read rejected.
      step(1'b1, 1'b1, 4'hA);
      chk_status("emptyrw", 1);
      check("emptyrw.out", 32'(bus.out), 32'hA);
      check("emptyrw.unf", 32'(bus.o_underflow), 32'(STICKY));
      check("emptyrw.ovf_hold", 32'(bus.o_overflow), 32'(STICKY));

      // Refill to full behind A.
      for (int i = 1; i <= 7; i++) begin
         step(1'b1, 1'b0, 4'(i));
         chk_status("refill", i + 1);
         check("refill.out", 32'(bus.out), 32'hA);
      end

      // rd+wr while full: count holds, head advances.
      step(1'b1, 1'b1, 4'h9);
      chk_status("fullrw", 8);
      check("fullrw.out", 32'(bus.out), 32'(1));

      // Drain 1..7 then 9.
      for (int i = 0; i < 8; i++) begin
         check("drain2.out", 32'(bus.out), (i < 7) ? 32'(i + 1) : 32'h9);
         step(1'b0, 1'b1, 4'h0);
         chk_status("drain2", 7 - i);
      end

      // 3-in/2-out bursts across pointer wrap.
      written = 0;
      while (written < 20) begin
         for (int k = 0; k < 3; k++) begin
            if (written < 20) begin
               mstep(1'b1, 1'b0, 4'(written + 3));
               written++;
            end
         end
         for (int k = 0; k < 2; k++) mstep(1'b0, 1'b1, 4'h0);
      end
      while (q.size() > 0) mstep(1'b0, 1'b1, 4'h0);
      chk_status("burst.end", 0);

      // Reset with a partially filled queue and rd/wr active.
      for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 4'(i + 2));
      chk_status("pre_rst", 5);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b0, 1'b1, 4'h0);
      step(1'b1, 1'b0, 4'h1);
      step(1'b1, 1'b0, 4'h2);
      step(1'b1, 1'b0, 4'h3);
      step(1'b1, 1'b0, 4'h4);
      step(1'b1, 1'b0, 4'h5);
      chk_status("pre_rst2", 5);
      reset = 1'b1;
      step(1'b1, 1'b1, 4'h7);
      reset = 1'b0;
      chk_status("midrst", 0);
      check("midrst.ovf", 32'(bus.o_overflow), 32'(0));
      check("midrst.unf", 32'(bus.o_underflow), 32'(0));

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule

// File: doc/fifo_sync_param.md
FIFO_SYNC_PARAM -- requirements
Module: fifo_sync_param

Interface
REQ-001 The block SHALL provide parameter bw, default 4, bit width of one SIMD lane.
REQ-002 The block SHALL provide parameter simd, default 1, lanes per entry; entry width W = simd*bw.
REQ-003 The block SHALL provide parameter depth, default 64, entry count; legal values are powers of two, 2 to 1024.
REQ-004 The block SHALL provide parameter af_level, default 60, count threshold for almost-full; legal range 1 to depth.
REQ-005 The block SHALL provide parameter ae_level, default 4, count threshold for almost-empty; legal range 0 to depth-1.
REQ-006 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-007 The block SHALL have port reset, input, 1, synchronous active-high reset.
REQ-008 The block SHALL have port in, input, W, write data.
REQ-009 The block SHALL have port wr, input, 1, write request.
REQ-010 The block SHALL have port rd, input, 1, read request (pop).
REQ-011 The block SHALL have port out, output, W, head-of-queue data.
REQ-012 The block SHALL have port o_full, output, 1, high when count == depth.
REQ-013 The block SHALL have port o_empty, output, 1, high when count == 0.
REQ-014 The block SHALL have port o_almost_full, output, 1, high when count >= af_level.
REQ-015 The block SHALL have port o_almost_empty, output, 1, high when count <= ae_level.
REQ-016 The block SHALL have port o_count, output, clog2(depth)+1, current occupancy 0 to depth.
REQ-017 The block SHALL have ports o_overflow and o_underflow, output, 1 each, sticky error flags.

Function
REQ-018 Storage SHALL be depth entries of W bits, addressed by wr_ptr and rd_ptr of clog2(depth)+1 bits; the MSB is the wrap bit.
REQ-019 All status outputs (o_full, o_empty, o_almost_full, o_almost_empty, o_count) SHALL be registered or derived combinationally from registered pointers only; no path from rd/wr to status in the same cycle.
REQ-020 A write SHALL be accepted when wr=1 and (o_full=0 or an accepted read occurs in the same cycle); accepted write stores in at wr_ptr and increments wr_ptr.
REQ-021 A write with wr=1 while full and no accepted read SHALL NOT modify storage or wr_ptr (no overwrite of the oldest entry).
REQ-022 A read SHALL be accepted when rd=1 and o_empty=0; accepted read increments rd_ptr.
REQ-023 Simultaneous rd=1, wr=1 while empty SHALL accept the write only; the read is rejected (no bypass).
REQ-024 Simultaneous accepted read and write SHALL leave o_count unchanged.
REQ-025 out SHALL be combinationally mem[rd_ptr] (show-ahead, zero read latency); data written at cycle N is visible on out in cycle N+1 when it is the head.
REQ-026 Pointers SHALL wrap modulo 2*depth; full/empty SHALL be correct across any number of wraps.
REQ-027 o_count SHALL equal wr_ptr - rd_ptr modulo 2*depth.

Reset
REQ-028 With reset=1 at a clk edge, rd_ptr, wr_ptr, o_count SHALL become 0, o_empty=1, o_full=0, o_almost_empty=1, o_almost_full=0, o_overflow=0, o_underflow=0.
REQ-029 Reset SHALL take priority over rd and wr in the same cycle, including mid-operation with a partially filled queue.
REQ-030 Storage contents SHALL NOT be reset; out is unspecified until the head entry has been written.

Configuration
REQ-031 With macro FIFO_ERR_STICKY_EN defined, o_overflow SHALL set on a rejected write (REQ-021) and o_underflow on a rejected read, each held until reset.
REQ-032 Without FIFO_ERR_STICKY_EN, o_overflow and o_underflow SHALL be constant 0 and no error-flag registers SHALL be generated.

Verification (depth=8, bw=4, simd=1, af_level=6, ae_level=1)
REQ-033 Reset, write 1..8 -> o_count 1..8, o_almost_full at count 6, o_full at 8; read 8 -> out 1..8 in order, o_empty after last.
REQ-034 Full, wr=1 in=F, rd=0 -> queue unchanged, out still 1, o_overflow=1 (macro defined) or 0 (undefined).
REQ-035 Full, rd=1 wr=1 in=9 -> o_count stays 8, out becomes 2; after draining, 9 is last out.
REQ-036 Empty, rd=1 wr=1 in=A -> o_count=1, out=A next cycle, o_underflow=1 (macro defined).
REQ-037 Write/read 20 entries in 3-in/2-out bursts -> data order preserved across pointer wrap, o_count matches model every cycle.
REQ-038 Count 5 then reset with rd=1 wr=1 -> next cycle o_count=0, o_empty=1, all flags cleared.
